mul_div_sequencer: RTL and testbench

Multi-cycle sequencer for the PRODUCT and DIVISION ALU operations, which are too slow for a single-cycle ALU path. It accepts an operation from the execute stage and iterates a shift-add multiplier or restoring divider for WIDTH cycles. While it works, it holds the pipeline stalled, then presents the registered result with a one-cycle done pulse. It sits beside the main ALU and is selected by the same 4-bit ALU control code.

---
 rtl/mul_div_sequencer_pkg.sv | 34 +++
 rtl/mul_div_step.sv | 67 ++++++
 rtl/mul_div_sequencer.sv | 176 +++++++++++++++++
 tb/tb_mul_div_sequencer.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/mul_div_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// mul_div_sequencer_pkg
// Shared definitions for the multi-cycle multiply/divide sequencer:
//   - ALU control codes decoded by the execute stage (4 bits)
//   - sequencer FSM state encoding
//   - helper that tells whether an ALU code belongs to this block
// No ports; imported by mul_div_step and mul_div_sequencer.
// -----------------------------------------------------------------------------
package mul_div_sequencer_pkg;

   localparam logic [3:0] ALU_NOP = 4'b0000;
   localparam logic [3:0] ALU_ADD = 4'b0001;
   localparam logic [3:0] ALU_SUB = 4'b0010;
   localparam logic [3:0] ALU_MUL = 4'b0011;
   localparam logic [3:0] ALU_DIV = 4'b0100;
   localparam logic [3:0] ALU_AND = 4'b0101;
   localparam logic [3:0] ALU_OR  = 4'b0110;
   localparam logic [3:0] ALU_NOR = 4'b0111;
   localparam logic [3:0] ALU_SLT = 4'b1000;
   localparam logic [3:0] ALU_XOR = 4'b1001;

   typedef enum logic [1:0] {
      SEQ_IDLE = 2'b00,
      SEQ_MUL  = 2'b01,
      SEQ_DIV  = 2'b10,
      SEQ_FIN  = 2'b11
   } seqState_t;

   // True for the ALU codes that this sequencer executes.
   function automatic logic isSeqOp(input logic [3:0] aluSel);
      return (aluSel == ALU_MUL) || (aluSel == ALU_DIV);
   endfunction

endpackage

// File: rtl/mul_div_step.sv
// -----------------------------------------------------------------------------
// mul_div_step
// Combinational single-iteration datapath shared by multiply and divide.
//   divMode  in   1        0 = shift-add multiply step, 1 = restoring divide step
//   accIn    in   WIDTH+1  accumulator (multiply) / partial remainder (divide)
//   opAIn    in   WIDTH    multiplicand (multiply) / dividend-quotient shifter (divide)
//   opBIn    in   WIDTH    multiplier (multiply) / divisor (divide)
//   accOut   out  WIDTH+1  next accumulator / remainder
//   opAOut   out  WIDTH    next multiplicand / dividend-quotient shifter
//   opBOut   out  WIDTH    next multiplier / divisor
// In divide mode opA carries the unconsumed dividend bits in its upper end and
// collects quotient bits at its LSB, so after WIDTH steps it holds the quotient.
// -----------------------------------------------------------------------------
module mul_div_step
   import mul_div_sequencer_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             divMode,
   input  logic [WIDTH:0]   accIn,
   input  logic [WIDTH-1:0] opAIn,
   input  logic [WIDTH-1:0] opBIn,
   output logic [WIDTH:0]   accOut,
   output logic [WIDTH-1:0] opAOut,
   output logic [WIDTH-1:0] opBOut
);

   logic [WIDTH:0]   shiftedRem_s;
   logic [WIDTH+1:0] trial_s;
   logic             canSub_s;
   logic [WIDTH-1:0] addend_s;
   logic [WIDTH-1:0] mulSum_s;

   // One multiply or divide iteration.
   always_comb begin
      // Divide: bring the next dividend bit into the remainder and try subtracting.
      shiftedRem_s = {accIn[WIDTH-1:0], opAIn[WIDTH-1]};
      trial_s      = {1'b0, shiftedRem_s} - {2'b00, opBIn};
      // A set top remainder bit means the shifted value already exceeds any divisor.
      canSub_s     = accIn[WIDTH] | ~trial_s[WIDTH+1];

      // Multiply: add the multiplicand when the current multiplier bit is set;
      // the sum is kept modulo 2^WIDTH.
      addend_s = opBIn[0] ? opAIn : {WIDTH{1'b0}};
      mulSum_s = accIn[WIDTH-1:0] + addend_s;

      accOut = {(WIDTH+1){1'b0}};
      opAOut = {WIDTH{1'b0}};
      opBOut = {WIDTH{1'b0}};

      if (divMode) begin
         opBOut = opBIn;
         if (canSub_s) begin
            accOut = trial_s[WIDTH:0];
            opAOut = {opAIn[WIDTH-2:0], 1'b1};
         end else begin
            accOut = shiftedRem_s;
            opAOut = {opAIn[WIDTH-2:0], 1'b0};
         end
      end else begin
         accOut = {1'b0, mulSum_s};
         opAOut = {opAIn[WIDTH-2:0], 1'b0};
         opBOut = {1'b0, opBIn[WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/mul_div_sequencer.sv
// -----------------------------------------------------------------------------
// mul_div_sequencer
// Multi-cycle sequencer for the PRODUCT and DIVISION ALU operations. Accepts a
// request from the execute stage, iterates WIDTH shift-add / restoring-divide
// steps while stalling the pipeline, then presents a registered result with a
// one-cycle done pulse.
//   clk          in   1      rising-edge clock
//   rst          in   1      synchronous active-high reset
//   start        in   1      execute stage requests an operation
//   ALUsel       in   4      ALU control code (ALU_MUL / ALU_DIV handled here)
//   a            in   WIDTH  multiplicand / dividend (unsigned)
//   b            in   WIDTH  multiplier / divisor (unsigned)
//   stall        out  1      freeze upstream stages (combinational)
//   busy         out  1      iteration in progress (registered)
//   done         out  1      one-cycle result-valid pulse (registered)
//   result       out  WIDTH  product low bits or quotient, held between ops
//   div_by_zero  out  1      last divide had b == 0
// -----------------------------------------------------------------------------
module mul_div_sequencer
   import mul_div_sequencer_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [3:0]       ALUsel,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             stall,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             div_by_zero
);

   localparam int                CNT_W    = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   seqState_t        state_r,     nextState_s;
   logic [WIDTH:0]   accum_r,     accumNext_s;
   logic [WIDTH-1:0] opA_r,       opANext_s;
   logic [WIDTH-1:0] opB_r,       opBNext_s;
   logic [CNT_W-1:0] count_r,     countNext_s;
   logic             busy_r,      busyNext_s;
   logic             done_r,      doneNext_s;
   logic [WIDTH-1:0] result_r,    resultNext_s;
   logic             divByZero_r, divByZeroNext_s;

   logic             stepDiv_s;
   logic [WIDTH:0]   stepAcc_s;
   logic [WIDTH-1:0] stepOpA_s;
   logic [WIDTH-1:0] stepOpB_s;
   logic             accept_s;

   mul_div_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .divMode (stepDiv_s),
      .accIn   (accum_r),
      .opAIn   (opA_r),
      .opBIn   (opB_r),
      .accOut  (stepAcc_s),
      .opAOut  (stepOpA_s),
      .opBOut  (stepOpB_s)
   );

   // Request acceptance, stall and datapath mode decode.
   always_comb begin
      accept_s  = (state_r == SEQ_IDLE) && start && isSeqOp(ALUsel);
      // busy_r is low in FIN, so the pipeline moves on in the done cycle.
      stall     = busy_r | accept_s;
      stepDiv_s = (state_r == SEQ_DIV);
   end

   // Next-state and next-register logic for the sequencer FSM.
   always_comb begin
      nextState_s     = state_r;
      accumNext_s     = accum_r;
      opANext_s       = opA_r;
      opBNext_s       = opB_r;
      countNext_s     = count_r;
      busyNext_s      = busy_r;
      doneNext_s      = 1'b0;
      resultNext_s    = result_r;
      divByZeroNext_s = divByZero_r;

      case (state_r)
         SEQ_IDLE: begin
            if (accept_s) begin
               accumNext_s     = {(WIDTH+1){1'b0}};
               opANext_s       = a;
               opBNext_s       = b;
               countNext_s     = {CNT_W{1'b0}};
               divByZeroNext_s = 1'b0;
               if (ALUsel == ALU_MUL) begin
                  nextState_s = SEQ_MUL;
                  busyNext_s  = 1'b1;
               end else if (b == {WIDTH{1'b0}}) begin
                  // Divide by zero skips iteration and completes next cycle.
                  nextState_s     = SEQ_FIN;
                  doneNext_s      = 1'b1;
                  resultNext_s    = {WIDTH{1'b1}};
                  divByZeroNext_s = 1'b1;
               end else begin
                  nextState_s = SEQ_DIV;
                  busyNext_s  = 1'b1;
               end
            end else begin
               nextState_s = SEQ_IDLE;
            end
         end

         SEQ_MUL, SEQ_DIV: begin
            accumNext_s = stepAcc_s;
            opANext_s   = stepOpA_s;
            opBNext_s   = stepOpB_s;
            countNext_s = count_r + CNT_ONE;
            if (count_r == CNT_LAST) begin
               // Last iteration: capture the result so it is valid with done.
               nextState_s = SEQ_FIN;
               busyNext_s  = 1'b0;
               doneNext_s  = 1'b1;
               if (state_r == SEQ_DIV) begin
                  resultNext_s = stepOpA_s;
               end else begin
                  resultNext_s = stepAcc_s[WIDTH-1:0];
               end
            end else begin
               nextState_s = state_r;
            end
         end

         SEQ_FIN: begin
            nextState_s = SEQ_IDLE;
         end

         default: begin
            nextState_s = SEQ_IDLE;
            busyNext_s  = 1'b0;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= SEQ_IDLE;
         accum_r     <= {(WIDTH+1){1'b0}};
         opA_r       <= {WIDTH{1'b0}};
         opB_r       <= {WIDTH{1'b0}};
         count_r     <= {CNT_W{1'b0}};
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         result_r    <= {WIDTH{1'b0}};
         divByZero_r <= 1'b0;
      end else begin
         state_r     <= nextState_s;
         accum_r     <= accumNext_s;
         opA_r       <= opANext_s;
         opB_r       <= opBNext_s;
         count_r     <= countNext_s;
         busy_r      <= busyNext_s;
         done_r      <= doneNext_s;
         result_r    <= resultNext_s;
         divByZero_r <= divByZeroNext_s;
      end
   end

   assign busy        = busy_r;
   assign done        = done_r;
   assign result      = result_r;
   assign div_by_zero = divByZero_r;

endmodule

// File: tb/tb_mul_div_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mul_div_sequencer
// Self-checking bench for mul_div_sequencer (WIDTH = 32). Expected results come
// from plain arithmetic (64-bit product, integer division) and the documented
// cycle timing: busy in cycles 1..W, done in cycle W+1 (cycle 1 for b == 0).
// -----------------------------------------------------------------------------
module tb_mul_div_sequencer;

   localparam int W = 32;
   localparam logic [3:0] OP_MUL = 4'b0011;
   localparam logic [3:0] OP_DIV = 4'b0100;
   localparam logic [3:0] OP_ADD = 4'b0001;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [3:0]   ALUsel;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         stall;
   logic         busy;
   logic         done;
   logic [W-1:0] result;
   logic         div_by_zero;

   int           total = 0;
   int           bad   = 0;
   int           opIdx = 0;
   logic [W-1:0] prevResult;

   mul_div_sequencer #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .ALUsel      (ALUsel),
      .a           (a),
      .b           (b),
      .stall       (stall),
      .busy        (busy),
      .done        (done),
      .result      (result),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Issue one operation in the current cycle (cycle 0) and check every cycle
   // up to W+4. pokeCycle > 0 re-asserts start in that cycle (must be ignored).
   task automatic runOp(input logic [3:0] sel, input logic [W-1:0] aIn,
                        input logic [W-1:0] bIn, input int pokeCycle);
      logic [63:0]  prod;
      logic [W-1:0] expRes;
      logic         expDbz;
      int           expDone;
      logic         busyExp;
      opIdx++;
      prod    = {32'd0, aIn} * {32'd0, bIn};
      expDbz  = 1'b0;
      expDone = W + 1;
      if (sel == OP_MUL) begin
         expRes = prod[W-1:0];
      end else if (bIn == '0) begin
         expRes  = '1;
         expDbz  = 1'b1;
         expDone = 1;
      end else begin
         expRes = aIn / bIn;
      end

      ALUsel = sel;
      a      = aIn;
      b      = bIn;
      start  = 1'b1;
      #1;
      check($sformatf("op%0d c0 stall", opIdx), {63'd0, stall}, 64'd1);

      for (int c = 1; c <= W + 4; c++) begin
         @(posedge clk);
         #1;
         start  = (c == pokeCycle);
         ALUsel = OP_DIV;
         a      = $urandom;
         b      = $urandom;
         #1;
         busyExp = !expDbz && (c <= W);
         check($sformatf("op%0d c%0d busy", opIdx, c), {63'd0, busy}, {63'd0, busyExp});
         check($sformatf("op%0d c%0d stall", opIdx, c), {63'd0, stall}, {63'd0, busyExp});
         check($sformatf("op%0d c%0d done", opIdx, c), {63'd0, done}, {63'd0, (c == expDone)});
         check($sformatf("op%0d c%0d result", opIdx, c), {32'd0, result},
               {32'd0, (c < expDone) ? prevResult : expRes});
         check($sformatf("op%0d c%0d dbz", opIdx, c), {63'd0, div_by_zero}, {63'd0, expDbz});
      end
      start      = 1'b0;
      prevResult = expRes;
   endtask

   initial begin
      logic [3:0]   rSel;
      logic [W-1:0] rA;
      logic [W-1:0] rB;

      rst        = 1'b1;
      start      = 1'b0;
      ALUsel     = 4'b0000;
      a          = '0;
      b          = '0;
      prevResult = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      check("reset busy", {63'd0, busy}, 64'd0);
      check("reset done", {63'd0, done}, 64'd0);
      check("reset result", {32'd0, result}, 64'd0);
      check("reset dbz", {63'd0, div_by_zero}, 64'd0);
      check("reset stall", {63'd0, stall}, 64'd0);

      // Directed operations.
      runOp(OP_MUL, 32'd7, 32'd6, 0);
      runOp(OP_DIV, 32'd100, 32'd7, 0);
      runOp(OP_DIV, 32'hFFFF_FFFF, 32'd1, 0);
      runOp(OP_MUL, 32'hFFFF_FFFF, 32'd2, 0);
      runOp(OP_MUL, 32'd0, 32'h1234_5678, 0);
      runOp(OP_DIV, 32'd5, 32'd0, 0);
      runOp(OP_MUL, 32'd3, 32'd5, 0);

      // Start with a code outside this block: nothing happens.
      ALUsel = OP_ADD;
      a      = 32'd9;
      b      = 32'd9;
      start  = 1'b1;
      #1;
      check("alu add stall", {63'd0, stall}, 64'd0);
      for (int c = 1; c <= 5; c++) begin
         @(posedge clk);
         #1;
         start = 1'b0;
         #1;
         check($sformatf("alu add c%0d busy", c), {63'd0, busy}, 64'd0);
         check($sformatf("alu add c%0d done", c), {63'd0, done}, 64'd0);
         check($sformatf("alu add c%0d result", c), {32'd0, result}, {32'd0, prevResult});
      end

      // Start pulses during iteration and in the done cycle are ignored.
      runOp(OP_MUL, 32'd1234, 32'd5678, 10);
      runOp(OP_MUL, 32'h0000_DEAD, 32'h0000_BEEF, W + 1);

      // Reset in cycle 15 of a divide aborts it.
      ALUsel = OP_DIV;
      a      = 32'd100;
      b      = 32'd7;
      start  = 1'b1;
      for (int c = 1; c <= 15; c++) begin
         @(posedge clk);
         #1;
         start = 1'b0;
         if (c == 15) begin
            rst = 1'b1;
         end
      end
      #1;
      check("abort c15 busy", {63'd0, busy}, 64'd1);
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      check("abort busy", {63'd0, busy}, 64'd0);
      check("abort result", {32'd0, result}, 64'd0);
      check("abort done", {63'd0, done}, 64'd0);
      check("abort stall", {63'd0, stall}, 64'd0);
      for (int c = 0; c < 3; c++) begin
         @(posedge clk);
         #1;
         check($sformatf("abort +%0d done", c), {63'd0, done}, 64'd0);
         check($sformatf("abort +%0d busy", c), {63'd0, busy}, 64'd0);
      end
      prevResult = '0;
      runOp(OP_MUL, 32'd3, 32'd4, 0);

      // Randomized operations against the arithmetic reference.
      for (int i = 0; i < 24; i++) begin
         rSel = ($urandom_range(0, 1) == 0) ? OP_MUL : OP_DIV;
         rA   = $urandom;
         case ($urandom_range(0, 3))
            0:       rB = '0;
            1:       rB = W'($urandom_range(1, 255));
            default: rB = $urandom;
         endcase
         runOp(rSel, rA, rB, 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
